alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 4-bit shift/add/sub ALU datapath between two requesters.
- Arbitrates round-robin, latches the winner's operands, drives the ALU and registers its result.
- Returns the result on a valid/ready response channel tagged with the requester id.
- Sits between the requesting control logic and the combinational ALU; the ALU is outside this block, connected via the alu_* ports.

Parameters:
- W, 4, operand/result width (inA, inB, ans)
- SW, 2, shift-amount width (inC)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  W  requester 0 operand A
- req0_b  in  W  requester 0 operand B
- req0_c  in  SW  requester 0 shift amount
- req0_op  in  2  requester 0 opcode: 00 arithmetic shift right A by C, 01 logical shift right A by C, 10 A-B, 11 A+B
- req1_valid, req1_ready, req1_a, req1_b, req1_c, req1_op  same as requester 0, for requester 1
- alu_inA  out  W  operand A to ALU
- alu_inB  out  W  operand B to ALU
- alu_inC  out  SW  shift amount to ALU
- alu_op  out  2  opcode to ALU
- alu_ans  in  W  ALU combinational result
- rsp_valid  out  1  response holds a result
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that issued the result
- rsp_ans  out  W  registered result

Behaviour:
- States: IDLE, EXEC, RESP; state register resets to IDLE.
- Reset values: operand regs 0, op reg 0, rsp_ans 0, rsp_id 0, rsp_valid 0, priority pointer 0 (requester 0 favoured).
- All ALU drive outputs come straight from the operand regs, so they read 0 after reset.
- IDLE, arbitration:
  - grant0 = req0_valid & (!req1_valid | ptr==0)
  - grant1 = req1_valid & (!req0_valid | ptr==1)
  - reqN_ready = (state==IDLE) & grantN; at most one ready high per cycle.
  - Ready depends combinationally on both valids. Requesters must not make valid depend on ready.
- IDLE, on a handshake at edge N:
  - latch a/b/c/op and the id of the winner
  - ptr <= !winner_id
  - go to EXEC
- IDLE, no valid: stay in IDLE, ptr unchanged.
- EXEC (one cycle): rsp_ans <= alu_ans, rsp_id <= latched id, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_ans and rsp_id held stable until the handshake.
  - rsp_ready=1 at an edge: rsp_valid <= 0, go to IDLE.
  - No request is accepted in EXEC or RESP: both ready outputs are 0.
- Latency: request accepted at edge N; rsp_valid high from after edge N+1. With rsp_ready tied high, the response is consumed at edge N+2 and the next request can be accepted at edge N+3. Throughput is one operation per 3 cycles minimum.
- Arithmetic: the block never computes anything itself; results are whatever alu_ans returns, W bits with wrap-around (e.g. 9+9 -> 2, 2-3 -> 15).
- Fairness: with both valids held high continuously, grants alternate 0,1,0,1,... starting from the pointer value.
- Reset mid-operation, in any state: next cycle state = IDLE, rsp_valid = 0, ptr = 0. The in-flight result is discarded and no response is emitted for it.
- A request valid during reset is not accepted during reset; it may be accepted in the first cycle after reset.

Decomposition:
- Shared package holds:
  - opcode constants OP_SRA=2'b00, OP_SRL=2'b01, OP_SUB=2'b10, OP_ADD=2'b11
  - the state enum (IDLE, EXEC, RESP)
  - widths W and SW
- One sub-module: rr_arb2, a combinational 2-way round-robin grant from valids and ptr. The ptr register stays in alu_arbiter.

Test Plan:
- Reset, then req0 op=11 a=3 b=5 -> req0_ready=1 that cycle; rsp_valid=1 two edges later with rsp_ans=8, rsp_id=0; returns to IDLE after rsp_ready.
- After reset, both valid in the same cycle: req0 op=10 a=2 b=3, req1 op=00 a=4'b1000 c=2 -> first response id=0 ans=4'hF, then id=1 ans=4'b1110; req1 is not readied until state returns to IDLE.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with req0/req1 valid -> rsp_ans/rsp_id stable, both ready outputs 0; consumed on the first rsp_ready=1 edge.
- Fairness: both valids held high for 4 operations -> ids 0,1,0,1; with only req1 valid and ptr=0 -> req1 granted immediately.
- Width/ops: req1 op=01 a=4'b1000 c=3 -> 1; op=11 a=9 b=9 -> 2; op=00 a=4'b0110 c=1 -> 3.
- Reset asserted during EXEC -> next cycle rsp_valid=0, state IDLE, no response for the dropped op; a subsequent req1-only request gets id=1 with the correct result.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared widths, opcodes and controller state encoding for the ALU arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_arbiter_pkg;

  localparam int W  = 4;
  localparam int SW = 2;

  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; ptr selects the favoured requester on a tie.
// Latency: purely combinational.
// Backpressure: none here; the caller gates grants with its own busy state.
module rr_arb2 (
  input  logic vld0,
  input  logic vld1,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1
);

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    gnt0 = vld0 & (~vld1 | ~ptr);
    gnt1 = vld1 & (~vld0 |  ptr);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external shift/add/sub ALU between two requesters, round-robin.
// Latency: accept at edge N, result registered at N+1, rsp_valid seen after N+1.
// Backpressure: response held until rsp_ready; no request accepted while busy.
module alu_arbiter #(
  parameter int W  = alu_arbiter_pkg::W,
  parameter int SW = alu_arbiter_pkg::SW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [SW-1:0] req0_c,
  input  logic [1:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic [SW-1:0] req1_c,
  input  logic [1:0]    req1_op,
  output logic [W-1:0]  alu_inA,
  output logic [W-1:0]  alu_inB,
  output logic [SW-1:0] alu_inC,
  output logic [1:0]    alu_op,
  input  logic [W-1:0]  alu_ans,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_ans
);

  import alu_arbiter_pkg::*;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [SW-1:0] c_q, c_d;
  logic [1:0]    op_q, op_d;
  logic          id_q, id_d;
  logic [W-1:0]  rsp_ans_q, rsp_ans_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_valid_q, rsp_valid_d;

  logic gnt0, gnt1;
  logic idle;

  rr_arb2 u_rr_arb2 (
    .vld0 (req0_valid),
    .vld1 (req1_valid),
    .ptr  (ptr_q),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign idle       = (state_q == IDLE);
  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;

  // The ALU is driven only from latched operands so it is stable for the EXEC cycle.
  assign alu_inA = a_q;
  assign alu_inB = b_q;
  assign alu_inC = c_q;
  assign alu_op  = op_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ans   = rsp_ans_q;

  // Next-state: accept the winner in IDLE, capture the ALU result in EXEC, hold in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_ans_d   = rsp_ans_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (gnt1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          c_d     = req1_c;
          op_d    = req1_op;
          id_d    = 1'b1;
          ptr_d   = 1'b0;
          state_d = EXEC;
        end else if (gnt0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          c_d     = req0_c;
          op_d    = req0_op;
          id_d    = 1'b0;
          ptr_d   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_ans_d   = alu_ans;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_ans_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_ans_q   <= rsp_ans_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized plus directed bench for alu_arbiter against a transaction-level model.
// Latency: model tracks accept edge and expects rsp_valid one edge later.
// Backpressure: rsp_ready is driven randomly and held low in a directed case.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_c, req0_op, req1_c, req1_op;
  logic [3:0] alu_inA, alu_inB, alu_ans;
  logic [1:0] alu_inC, alu_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_ans;

  int n_cmp = 0;
  int n_bad = 0;

  // transaction-level reference state
  bit         m_busy;
  int         m_acc;
  bit         m_id;
  logic [3:0] m_ans;
  bit         m_ptr;
  logic [3:0] m_la, m_lb;
  logic [1:0] m_lc, m_lop;
  int         edge_cnt = 0;
  int         obs_id[$];
  int         obs_ans[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [1:0] c);
    logic signed [3:0] sa;
    sa = a;
    case (op)
      2'b00:   return 4'(sa >>> c);
      2'b01:   return a >> c;
      2'b10:   return 4'(a - b);
      default: return 4'(a + b);
    endcase
  endfunction

  // external combinational ALU
  assign alu_ans = alu_ref(alu_op, alu_inA, alu_inB, alu_inC);

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c(req0_c), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c(req1_c), .req1_op(req1_op),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_op(alu_op), .alu_ans(alu_ans),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ans(rsp_ans)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] c);
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_c = c;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_c = c;
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, drive at +1.
  task automatic step();
    bit e_r0, e_r1, e_vld;
    int w;
    w = -1;
    @(negedge clk);
    if (!reset) begin
      e_r0  = !m_busy && req0_valid && (!req1_valid || !m_ptr);
      e_r1  = !m_busy && req1_valid && (!req0_valid || m_ptr);
      e_vld = m_busy && (edge_cnt >= m_acc + 1);
      check_eq("req0_ready", 32'(req0_ready), 32'(e_r0));
      check_eq("req1_ready", 32'(req1_ready), 32'(e_r1));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(e_vld));
      if (e_vld) begin
        check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
        check_eq("rsp_ans", 32'(rsp_ans), 32'(m_ans));
      end
      check_eq("alu_inA", 32'(alu_inA), 32'(m_la));
      check_eq("alu_inB", 32'(alu_inB), 32'(m_lb));
      check_eq("alu_inC", 32'(alu_inC), 32'(m_lc));
      check_eq("alu_op", 32'(alu_op), 32'(m_lop));
      if (rsp_valid && rsp_ready) begin
        obs_id.push_back(int'(rsp_id));
        obs_ans.push_back(int'(rsp_ans));
      end
    end
    @(posedge clk);
    edge_cnt++;
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_la = 0; m_lb = 0; m_lc = 0; m_lop = 0;
    end else if (m_busy) begin
      if (edge_cnt >= m_acc + 2 && rsp_ready) m_busy = 0;
    end else if (req0_valid || req1_valid) begin
      w = (req0_valid && req1_valid) ? int'(m_ptr) : int'(req1_valid);
      if (w == 1) begin
        m_la = req1_a; m_lb = req1_b; m_lc = req1_c; m_lop = req1_op;
      end else begin
        m_la = req0_a; m_lb = req0_b; m_lc = req0_c; m_lop = req0_op;
      end
      m_ans  = alu_ref(m_lop, m_la, m_lb, m_lc);
      m_id   = (w == 1);
      m_busy = 1;
      m_acc  = edge_cnt;
      m_ptr  = (w == 0);
    end
    #1;
    if (w == 0) req0_valid = 1'b0;
    if (w == 1) req1_valid = 1'b1 ? 1'b0 : 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    reset = 1'b0;
    obs_id.delete();
    obs_ans.delete();
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k;
    k = 0;
    while (obs_id.size() < n && k < budget) begin
      step();
      k++;
    end
    if (obs_id.size() < n) check_eq("timeout", 32'(obs_id.size()), 32'(n));
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_c = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_c = 0; req1_op = 0;
    m_busy = 0; m_ptr = 0; m_la = 0; m_lb = 0; m_lc = 0; m_lop = 0; m_ans = 0; m_id = 0; m_acc = 0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_rsp_ans", 32'(rsp_ans), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    step();

    // single add from requester 0
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 2'b11, 4'd3, 4'd5, 2'd0);
    wait_obs(1, 10);
    step();
    if (obs_id.size() >= 1) begin
      check_eq("add_id", 32'(obs_id[0]), 32'd0);
      check_eq("add_ans", 32'(obs_ans[0]), 32'd8);
    end

    // simultaneous requests: 0 first, then 1
    do_reset();
    set_req(0, 2'b10, 4'd2, 4'd3, 2'd0);
    set_req(1, 2'b00, 4'b1000, 4'd0, 2'd2);
    wait_obs(2, 20);
    if (obs_id.size() >= 2) begin
      check_eq("tie_id0", 32'(obs_id[0]), 32'd0);
      check_eq("tie_ans0", 32'(obs_ans[0]), 32'hF);
      check_eq("tie_id1", 32'(obs_id[1]), 32'd1);
      check_eq("tie_ans1", 32'(obs_ans[1]), 32'b1110);
    end

    // backpressure in RESP with both requesters waiting
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 2'b11, 4'd1, 4'd2, 2'd0);
    step();
    step();
    set_req(0, 2'b11, 4'd4, 4'd4, 2'd0);
    set_req(1, 2'b10, 4'd7, 4'd1, 2'd0);
    repeat (5) step();
    rsp_ready = 1'b1;
    wait_obs(1, 4);
    if (obs_id.size() >= 1) begin
      check_eq("bp_id", 32'(obs_id[0]), 32'd0);
      check_eq("bp_ans", 32'(obs_ans[0]), 32'd3);
    end

    // fairness with both valids held continuously
    do_reset();
    for (int k = 0; k < 40 && obs_id.size() < 4; k++) begin
      if (!req0_valid) set_req(0, 2'($urandom_range(3, 0)), 4'($urandom), 4'($urandom), 2'($urandom));
      if (!req1_valid) set_req(1, 2'($urandom_range(3, 0)), 4'($urandom), 4'($urandom), 2'($urandom));
      step();
    end
    check_eq("fair_count", 32'(obs_id.size()), 32'd4);
    if (obs_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) check_eq("fair_id", 32'(obs_id[k]), 32'(k % 2));
    end

    // requester 1 alone with ptr at 0, then three op/width cases
    do_reset();
    set_req(1, 2'b01, 4'b1000, 4'd0, 2'd3);
    wait_obs(1, 10);
    set_req(1, 2'b11, 4'd9, 4'd9, 2'd0);
    wait_obs(2, 10);
    set_req(1, 2'b00, 4'b0110, 4'd0, 2'd1);
    wait_obs(3, 10);
    if (obs_id.size() >= 3) begin
      check_eq("solo_id", 32'(obs_id[0]), 32'd1);
      check_eq("srl_ans", 32'(obs_ans[0]), 32'd1);
      check_eq("wrap_ans", 32'(obs_ans[1]), 32'd2);
      check_eq("sra_ans", 32'(obs_ans[2]), 32'd3);
    end

    // reset while in EXEC drops the operation
    do_reset();
    set_req(0, 2'b11, 4'd1, 4'd1, 2'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(1, 2'b10, 4'd5, 4'd1, 2'd0);
    wait_obs(1, 10);
    step();
    check_eq("drop_count", 32'(obs_id.size()), 32'd1);
    if (obs_id.size() >= 1) begin
      check_eq("drop_id", 32'(obs_id[0]), 32'd1);
      check_eq("drop_ans", 32'(obs_ans[0]), 32'd4);
    end

    // random traffic with random backpressure and occasional reset
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (!req0_valid && $urandom_range(1, 0) == 1)
        set_req(0, 2'($urandom_range(3, 0)), 4'($urandom), 4'($urandom), 2'($urandom));
      if (!req1_valid && $urandom_range(1, 0) == 1)
        set_req(1, 2'($urandom_range(3, 0)), 4'($urandom), 4'($urandom), 2'($urandom));
      rsp_ready = ($urandom_range(3, 0) != 0);
      reset = ($urandom_range(99, 0) == 0);
      step();
    end
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
